// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter sharing one FIFO write port among NREQ requesters.
//   Each grant is a burst of up to MAX_BURST words. FIFO back-pressure
//   (fifo_afull) stalls the burst without ending it. The write enable and
//   write data are registered, so a word lands in the FIFO one edge after
//   its acknowledge.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   req        per-requester write request, held while it has data
//   din        packed requester data, requester i on [i*DW +: DW]
//   ack        one-hot, combinational: din slice consumed at this edge
//   gnt        one-hot registered owner, 0 when idle
//   fifo_afull FIFO has at most one free slot
//   fifo_we    registered FIFO write enable
//   fifo_din   registered FIFO write data
//   busy       registered, high while a burst is granted
module fifo_write_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   din,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      gnt,
   input  logic                 fifo_afull,
   output logic                 fifo_we,
   output logic [DW-1:0]        fifo_din,
   output logic                 busy
);

   localparam int unsigned OW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(MAX_BURST) + 1;

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e             state_q;
   logic [OW-1:0]      owner_q;
   logic [OW-1:0]      last_q;
   logic [CW-1:0]      cnt_q;
   logic [NREQ-1:0]    gnt_q;
   logic               we_q;
   logic [DW-1:0]      wdata_q;
   logic               busy_q;

   logic               owner_req;
   logic               owner_ack;
   logic               last_word;
   logic [DW-1:0]      owner_din;
   logic               sel_found;
   logic [OW-1:0]      sel_idx;
   logic [OW-1:0]      cand;

   // Owner-side handshake: only the current owner can ever be acknowledged.
   always_comb begin
      owner_req = req[owner_q];
      owner_ack = (state_q == StBurst) && owner_req && !fifo_afull;
      owner_din = din[DW*32'(owner_q) +: DW];
      last_word = (cnt_q == CW'(MAX_BURST - 1));
      ack       = '0;
      if (owner_ack) begin
         ack[owner_q] = 1'b1;
      end
   end

   // Round-robin pick: first asserted request after the previous owner, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = OW'((32'(last_q) + k) % NREQ);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         owner_q <= '0;
         last_q  <= OW'(NREQ - 1);
         cnt_q   <= '0;
         gnt_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Arbitration cycle never writes a word.
               we_q <= 1'b0;
               if (sel_found && !fifo_afull) begin
                  owner_q <= sel_idx;
                  gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StBurst;
               end
            end
            StBurst: begin
               if (owner_ack) begin
                  we_q    <= 1'b1;
                  wdata_q <= owner_din;
                  cnt_q   <= cnt_q + CW'(1);
               end else begin
                  we_q    <= 1'b0;
               end
               // A stall (afull with req held) is not an exit; only the burst
               // limit or the owner dropping its request ends the grant.
               if ((owner_ack && last_word) || !owner_req) begin
                  state_q <= StIdle;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  last_q  <= owner_q;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign gnt      = gnt_q;
   assign fifo_we  = we_q;
   assign fifo_din = wdata_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic, checked
// against a behavioural model. Expected FIFO words go into a queue that a
// separate monitor drains whenever the DUT asserts fifo_we.
module tb_fifo_write_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int MB   = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [NREQ*DW-1:0]   din;
   logic [NREQ-1:0]      ack;
   logic [NREQ-1:0]      gnt;
   logic                 fifo_afull;
   logic                 fifo_we;
   logic [DW-1:0]        fifo_din;
   logic                 busy;

   always #5 clk = ~clk;

   fifo_write_arbiter #(
      .NREQ      (NREQ),
      .DW        (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .din        (din),
      .ack        (ack),
      .gnt        (gnt),
      .fifo_afull (fifo_afull),
      .fifo_we    (fifo_we),
      .fifo_din   (fifo_din),
      .busy       (busy)
   );

   int              n_checks = 0;
   int              n_fail   = 0;
   int              we_count = 0;
   logic [DW-1:0]   exp_q[$];
   logic [DW-1:0]   mon_exp;

   // Reference model: owner index (-1 = nobody), words taken in this grant,
   // previous owner, and the registered write port contents.
   int              m_owner;
   int              m_last;
   int              m_words;
   logic            m_we;
   logic [DW-1:0]   m_din;
   int              seq[NREQ];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [DW-1:0] word(input int i);
      return DW'((i << 12) | (seq[i] & 32'hFFF));
   endfunction

   task automatic drive_din();
      for (int i = 0; i < NREQ; i++) din[i*DW +: DW] = word(i);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = NREQ - 1;
      m_words = 0;
      m_we    = 1'b0;
      m_din   = '0;
      exp_q.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"},      32'(ack),      32'd0);
      chk({tag, "_gnt"},      32'(gnt),      32'd0);
      chk({tag, "_fifo_we"},  32'(fifo_we),  32'd0);
      chk({tag, "_fifo_din"}, 32'(fifo_din), 32'd0);
      chk({tag, "_busy"},     32'(busy),     32'd0);
   endtask

   // Assert reset between edges, check outputs clear without a clock, release.
   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      #1 chk_all_zero(tag);
      model_reset();
      req        = '0;
      fifo_afull = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One clock cycle: drive inputs after the falling edge, compare the DUT
   // against the model, then advance the model across the next rising edge.
   task automatic cyc(input logic [NREQ-1:0] r, input logic af);
      logic [NREQ-1:0] ea;
      logic [NREQ-1:0] eg;
      int              c;
      int              o;
      @(negedge clk);
      req        = r;
      fifo_afull = af;
      drive_din();
      #1;
      ea = '0;
      eg = '0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         if (r[m_owner] && !af) ea[m_owner] = 1'b1;
      end
      chk("ack",      32'(ack),      32'(ea));
      chk("gnt",      32'(gnt),      32'(eg));
      chk("busy",     32'(busy),     32'(m_owner >= 0));
      chk("fifo_we",  32'(fifo_we),  32'(m_we));
      chk("fifo_din", 32'(fifo_din), 32'(m_din));
      if (m_owner < 0) begin
         m_we = 1'b0;
         if (r != '0 && !af) begin
            for (int k = 1; k <= NREQ; k++) begin
               c = (m_last + k) % NREQ;
               if (r[c]) begin
                  m_owner = c;
                  break;
               end
            end
            m_words = 0;
         end
      end else begin
         o = m_owner;
         if (ea != '0) begin
            m_we  = 1'b1;
            m_din = word(o);
            exp_q.push_back(word(o));
            seq[o]++;
            m_words++;
         end else begin
            m_we = 1'b0;
         end
         if ((ea != '0 && m_words == MB) || !r[o]) begin
            m_last  = o;
            m_owner = -1;
         end
      end
   endtask

   // Scoreboard monitor: every write the DUT presents must match the next
   // expected word.
   always @(posedge clk) begin
      #1;
      if (rst === 1'b1 && fifo_we === 1'b1) begin
         we_count++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL write_unexpected: got %0h expected none at %0t", fifo_din, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            if (fifo_din !== mon_exp) begin
               n_fail++;
               $display("FAIL write_data: got %0h expected %0h at %0t", fifo_din, mon_exp, $time);
            end
         end
      end
   end

   initial begin
      logic [NREQ-1:0] rr;
      int              snap;
      bit              found;

      rst        = 1'b1;
      req        = '0;
      fifo_afull = 1'b0;
      for (int i = 0; i < NREQ; i++) seq[i] = int'($urandom_range(0, 255));
      drive_din();
      model_reset();

      // Reset without any clock edge.
      #1 rst = 1'b0;
      #1 chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (3) cyc(4'b0000, 1'b0);

      // Single requester hitting the burst limit, then re-grant.
      repeat (14) cyc(4'b0010, 1'b0);
      repeat (2) cyc(4'b0000, 1'b0);

      // All requesting: round robin, 16 writes in 20 cycles from idle.
      cyc(4'b1111, 1'b0);
      snap = we_count;
      repeat (20) cyc(4'b1111, 1'b0);
      chk("throughput", 32'(we_count - snap), 32'd16);
      repeat (2) cyc(4'b0000, 1'b0);

      // Back-pressure: two words, three stalled cycles, two more words.
      repeat (3) cyc(4'b0001, 1'b0);
      repeat (3) cyc(4'b0001, 1'b1);
      repeat (2) cyc(4'b0001, 1'b0);
      repeat (2) cyc(4'b0000, 1'b0);

      // Early release: requester 0 drops after one word, 2 takes over.
      async_reset("reset2");
      repeat (2) cyc(4'b0101, 1'b0);
      repeat (6) cyc(4'b0100, 1'b0);
      repeat (3) cyc(4'b0101, 1'b0);
      repeat (2) cyc(4'b0000, 1'b0);

      // Async reset in the middle of requester 2's burst.
      found = 1'b0;
      for (int n = 0; n < 50 && !found; n++) begin
         cyc(4'b1111, 1'b0);
         if (m_owner == 2 && m_words >= 1) found = 1'b1;
      end
      chk("owner2_reached", 32'(found), 32'd1);
      async_reset("reset_mid");
      repeat (2) cyc(4'b1111, 1'b0);
      chk("first_grant_after_reset", 32'(gnt), 32'h1);
      repeat (6) cyc(4'b1111, 1'b0);

      // Random traffic with random back-pressure.
      rr = '0;
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) rr = NREQ'($urandom);
         cyc(rr, $urandom_range(0, 3) == 0);
      end
      repeat (4) cyc(4'b0000, 1'b0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
